// File: rtl/conv_pkg.sv
// Shared definitions for the convolution-engine arbiter: default engine
// geometry, the arbiter FSM state encoding and the round-robin pointer step.
package conv_pkg;

  localparam int DEF_N = 32;
  localparam int DEF_M = 4;
  localparam int DEF_T = 16;
  localparam int DEF_L = DEF_N - DEF_M + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Advance a round-robin pointer by one, wrapping at r (any r, not just 2^k).
  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned r);
    return (ptr + 1 >= r) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/conv_engine_arbiter_if.sv
// Stream bundle between the requesters, the arbiter and the shared engine.
// master: the arbiter's view.  slave: the view of the surrounding sources,
// sinks and engine.
interface conv_engine_arbiter_if
  import conv_pkg::*;
#(
  parameter int R = 4,
  parameter int T = DEF_T
);

  logic [R*T-1:0] req_x_data;
  logic [R-1:0]   req_x_valid;
  logic [R-1:0]   req_x_ready;
  logic [T-1:0]   req_y_data;
  logic [R-1:0]   req_y_valid;
  logic [R-1:0]   req_y_ready;
  logic [T-1:0]   eng_x_data;
  logic           eng_x_valid;
  logic           eng_x_ready;
  logic [T-1:0]   eng_y_data;
  logic           eng_y_valid;
  logic           eng_y_ready;

  modport master (
    input  req_x_data, req_x_valid, req_y_ready,
    input  eng_x_ready, eng_y_data, eng_y_valid,
    output req_x_ready, req_y_data, req_y_valid,
    output eng_x_data, eng_x_valid, eng_y_ready
  );

  modport slave (
    output req_x_data, req_x_valid, req_y_ready,
    output eng_x_ready, eng_y_data, eng_y_valid,
    input  req_x_ready, req_y_data, req_y_valid,
    input  eng_x_data, eng_x_valid, eng_y_ready
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin selector: returns the first asserted request
// found when scanning ptr, ptr+1, ... modulo R.
module rr_pick #(
  parameter  int R    = 4,
  localparam int LOGR = (R > 1) ? $clog2(R) : 1
) (
  input  logic [R-1:0]    req,
  input  logic [LOGR-1:0] ptr,
  output logic            found,
  output logic [LOGR-1:0] index
);

  logic [LOGR:0]   sum;
  logic [LOGR-1:0] cand;

  // Scan from the farthest offset down to ptr so the nearest request wins.
  always_comb begin
    found = 1'b0;
    index = '0;
    sum   = '0;
    cand  = '0;
    for (int k = R - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + (LOGR + 1)'(k);
      if (sum >= (LOGR + 1)'(R)) sum = sum - (LOGR + 1)'(R);
      cand = LOGR'(sum);
      if (req[cand]) begin
        found = 1'b1;
        index = cand;
      end
    end
  end

endmodule

// File: rtl/conv_engine_arbiter.sv
// Grants one shared 1-D convolution engine to one requester per job (N input
// samples), then routes that job's L outputs back to the same requester.
// Grants rotate round-robin; no data is registered, only control.
module conv_engine_arbiter
  import conv_pkg::*;
#(
  parameter  int R    = 4,
  parameter  int N    = DEF_N,
  parameter  int M    = DEF_M,
  parameter  int T    = DEF_T,
  localparam int LOGR = (R > 1) ? $clog2(R) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  conv_engine_arbiter_if.master bus,
  output logic                  busy,
  output logic [LOGR-1:0]       grant_id,
  output logic                  job_done
);

  localparam int L    = N - M + 1;
  localparam int INW  = (N > 1) ? $clog2(N) : 1;
  localparam int OUTW = (L > 1) ? $clog2(L) : 1;

  state_t          state;
  state_t          state_nxt;
  logic [INW-1:0]  in_cnt;
  logic [OUTW-1:0] out_cnt;
  logic [LOGR-1:0] rr_ptr;

  logic            pick_found;
  logic [LOGR-1:0] pick_idx;
  logic            x_hs;
  logic            y_hs;
  logic            in_last;
  logic            out_last;

  rr_pick #(.R(R)) u_rr_pick (
    .req   (bus.req_x_valid),
    .ptr   (rr_ptr),
    .found (pick_found),
    .index (pick_idx)
  );

  assign in_last  = (in_cnt == INW'(N - 1));
  assign out_last = (out_cnt == OUTW'(L - 1));
  assign x_hs     = (state == FEED)  && bus.req_x_valid[grant_id] && bus.eng_x_ready;
  assign y_hs     = (state == DRAIN) && bus.eng_y_valid && bus.req_y_ready[grant_id];
  assign busy     = (state != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state: grant in IDLE, leave FEED on the last sample, leave DRAIN on the last output.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_found)         state_nxt = FEED;
      FEED:    if (x_hs && in_last)    state_nxt = DRAIN;
      DRAIN:   if (y_hs && out_last)   state_nxt = IDLE;
      default:                         state_nxt = IDLE;
    endcase
  end

  // Job counters, grant latch and round-robin pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_cnt   <= '0;
      out_cnt  <= '0;
      rr_ptr   <= '0;
      grant_id <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant_id <= pick_idx;
            in_cnt   <= '0;
          end
        end
        FEED: begin
          if (x_hs) begin
            if (in_last) begin
              in_cnt  <= '0;
              out_cnt <= '0;
            end else begin
              in_cnt <= in_cnt + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (y_hs) begin
            if (out_last) begin
              out_cnt <= '0;
              rr_ptr  <= LOGR'(rr_next(32'(grant_id), R));
            end else begin
              out_cnt <= out_cnt + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Steer handshakes between the granted requester and the engine; data passes straight through.
  always_comb begin
    bus.req_x_ready = '0;
    bus.req_y_valid = '0;
    bus.eng_x_valid = 1'b0;
    bus.eng_y_ready = 1'b0;
    bus.eng_x_data  = bus.req_x_data[int'(grant_id) * T +: T];
    bus.req_y_data  = bus.eng_y_data;
    job_done        = y_hs && out_last;
    case (state)
      FEED: begin
        bus.eng_x_valid           = bus.req_x_valid[grant_id];
        bus.req_x_ready[grant_id] = bus.eng_x_ready;
      end
      DRAIN: begin
        bus.req_y_valid[grant_id] = bus.eng_y_valid;
        bus.eng_y_ready           = bus.req_y_ready[grant_id];
      end
      default: ;
    endcase
  end

endmodule

// File: doc/conv_engine_arbiter.md
Name: conv_engine_arbiter

Overview:
Shares one streaming 1-D convolution engine (N-sample input, M-tap filter, T-bit data, L=N-M+1 outputs) between R requesters. A job is one N-sample input vector. The block grants the engine to one requester for a whole job, then routes that job's L outputs back to the same requester. Grants rotate round-robin. It sits between the per-requester stream sources/sinks and the single conv engine instance.

Parameters:
R, 4, number of requesters
N, 32, input samples per job
M, 4, filter taps
T, 16, data word width
(derived) L = N-M+1; LOGR = max(1,$clog2(R)); counter widths $clog2(N), $clog2(L)

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
req_x_data  in  R*T  requester input samples; slice r = bits [r*T+T-1 : r*T]
req_x_valid  in  R  per-requester input valid
req_x_ready  out  R  per-requester input ready
req_y_data  out  T  output word, broadcast to all requesters
req_y_valid  out  R  per-requester output valid
req_y_ready  in  R  per-requester output ready
eng_x_data  out  T  to engine x_data
eng_x_valid  out  1  to engine x_valid
eng_x_ready  in  1  from engine x_ready
eng_y_data  in  T  from engine y_data
eng_y_valid  in  1  from engine y_valid
eng_y_ready  out  1  to engine y_ready
busy  out  1  high in FEED or DRAIN
grant_id  out  LOGR  index of the current or most recent grant
job_done  out  1  one-cycle pulse on the last output handshake of a job

Behaviour:
- States: IDLE, FEED, DRAIN.
- Reset: state IDLE; in_cnt=0; out_cnt=0; rr_ptr=0; grant_id=0. All ready and valid outputs 0; busy=0; job_done=0.
- IDLE: pick = first r in order rr_ptr, rr_ptr+1, ... (mod R) with req_x_valid[r]=1. If one exists: register grant_id=pick, set in_cnt=0, next state FEED. Otherwise stay in IDLE.
- Arbitration latency: 1 cycle from valid to grant. No handshake happens in IDLE.
- FEED (g = grant_id):
  - eng_x_valid = req_x_valid[g]; eng_x_data = slice g.
  - req_x_ready[g] = eng_x_ready; req_x_ready of every other requester = 0.
  - A handshake is eng_x_valid & eng_x_ready; each one increments in_cnt.
  - Handshake when in_cnt==N-1: clear out_cnt, go to DRAIN.
  - If the granted requester drops valid mid-job, hold the grant and wait indefinitely.
- DRAIN:
  - req_y_valid[g] = eng_y_valid; every other req_y_valid = 0.
  - eng_y_ready = req_y_ready[g]; req_y_data = eng_y_data.
  - Each handshake increments out_cnt.
  - Handshake when out_cnt==L-1: pulse job_done; rr_ptr = (g+1) mod R (wrap at R, including non-power-of-2 R); go to IDLE.
- Outside DRAIN: eng_y_ready=0 and all req_y_valid=0. Outside FEED: eng_x_valid=0 and all req_x_ready=0.
- req_x_ready, req_y_valid, eng_x_valid and eng_y_ready are combinational from the registered state/grant and the handshake inputs. No data is registered inside this block, so there is zero added data latency.
- Inter-job gap: exactly one IDLE cycle, even when other requesters are waiting.
- Ready/valid inputs of non-granted requesters are ignored. Their valid may stay high across jobs without being consumed.
- Reset mid-job: abandons the job and returns to the reset values above. The engine shares the same reset, so both restart clean.
- R=1: rr_ptr stays 0 and the block degenerates to a job sequencer.

Decomposition:
- Shared package conv_pkg holds:
  - default N, M, T and derived L
  - state typedef enum {IDLE, FEED, DRAIN}
  - function rr_next(ptr, R)
- One sub-module, rr_pick: combinational round-robin priority selector. Inputs: req vector and ptr. Outputs: found and index.
- Counters and FSM live in the top.

Test Plan:
- Single requester 0 streams 32 samples, all 1, with filter {-170,-170,-80,-10} and y_ready held high. Expect grant_id=0 in FEED, 29 outputs on req_y_valid[0] only, job_done once, then IDLE with rr_ptr=1.
- Requesters 0 and 2 assert valid together from reset. Expect job order 0 then 2. Exactly one IDLE cycle separates the last output of job 0 from the first req_x_ready[2].
- All 4 requesters continuously valid for 8 jobs. Expect grant sequence 0,1,2,3,0,1,2,3.
- Granted requester drops valid for 5 cycles after sample 10, then backpressures y_ready randomly. Expect grant held, in_cnt frozen at 10, no lost or duplicate words, and exactly 29 outputs.
- Reset asserted in DRAIN at out_cnt=12. Expect next cycle state=IDLE, all valids and readys 0, grant_id=0, and a clean full job afterwards.
- Non-granted requester 3 holds valid throughout requester 1's job. Expect req_x_ready[3]=0 and req_y_valid[3]=0 until its own grant.
